// File: rtl/sr_pkg.sv
// Shared types and next-state helper for the SR register bank.
// Holds the S=R=1 resolution modes and the per-bit next-state function.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_MODE_HOLD    = 2'd0,
    SR_MODE_SET_DOM = 2'd1,
    SR_MODE_RST_DOM = 2'd2,
    SR_MODE_TOGGLE  = 2'd3
  } sr_mode_t;

  function automatic logic sr_next(
    input logic     q,
    input logic     s,
    input logic     r,
    input sr_mode_t mode
  );
    logic n;
    n = q;
    unique case ({s, r})
      2'b10: n = 1'b1;
      2'b01: n = 1'b0;
      2'b11: begin
        unique case (mode)
          SR_MODE_SET_DOM: n = 1'b1;
          SR_MODE_RST_DOM: n = 1'b0;
          SR_MODE_TOGGLE:  n = ~q;
          default:         n = q;
        endcase
      end
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// Single SR bit: enabled update, sync clear, sticky conflict flag
// and registered one-cycle rise/fall pulses.
module sr_cell
  import sr_pkg::*;
#(
  parameter sr_mode_t MODE      = SR_MODE_HOLD,
  parameter logic     RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic conflict
);

  logic r_q;
  logic r_prev;
  logic r_rise;
  logic r_fall;
  logic r_conf;
  logic w_next;

  // next state for an enabled update
  always_comb begin
    w_next = sr_next(r_q, s, r, MODE);
  end

  // state bit; r_prev starts equal to q so release makes no pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= RESET_BIT;
      r_prev <= RESET_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      if (clr) begin
        r_q <= RESET_BIT;
      end else if (en) begin
        r_q <= w_next;
      end
      r_prev <= r_q;
      r_rise <= r_q & ~r_prev;
      r_fall <= ~r_q & r_prev;
    end
  end

  // sticky conflict flag, cleared only by reset or clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conf <= 1'b0;
    end else if (clr) begin
      r_conf <= 1'b0;
    end else if (en && s && r) begin
      r_conf <= 1'b1;
    end
  end

  assign q        = r_q;
  assign q_rise   = r_rise;
  assign q_fall   = r_fall;
  assign conflict = r_conf;

endmodule

// File: rtl/sr_reg_bank.sv
// WIDTH-channel clocked SR register bank with edge pulses and conflict flags.
// Optional saturating conflict-cycle counter under SR_CONFLICT_CNT_EN.
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               CONFLICT_MODE = int'(SR_MODE_HOLD),
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam sr_mode_t LP_MODE =
    sr_mode_t'(CONFLICT_MODE[1:0]);

  if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
    $error("sr_reg_bank: illegal CONFLICT_MODE");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_reg_bank: WIDTH out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sr_reg_bank: CNT_W must be positive");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE      (LP_MODE),
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clr      (clr),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .q_rise   (q_rise[i]),
      .q_fall   (q_fall[i]),
      .conflict (conflict[i])
    );
  end

  assign qbar = ~q;

`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_any;

  assign w_any = en & (|(s & r));

  // counts conflict cycles (not bits), saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_any && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign conflict_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank across HOLD/SET/RST/TOGGLE modes
// and a non-zero RESET_VAL instance sharing one stimulus stream.
module tb_sr_reg_bank;
  import sr_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic [3:0] s;
  logic [3:0] r;

  logic [3:0] h_q, h_qb, h_ri, h_fa, h_cf;
  logic [3:0] d_q, d_qb, d_ri, d_fa, d_cf;
  logic [3:0] k_q, k_qb, k_ri, k_fa, k_cf;
  logic [3:0] t_q, t_qb, t_ri, t_fa, t_cf;
  logic [3:0] v_q, v_qb, v_ri, v_fa, v_cf;
`ifdef SR_CONFLICT_CNT_EN
  logic [1:0] h_cnt;
  logic [7:0] d_cnt, k_cnt, t_cnt, v_cnt;
`endif

  int passed = 0;
  int total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(SR_MODE_HOLD),
                .RESET_VAL(4'b0000), .CNT_W(2)) u_hold (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(h_q), .qbar(h_qb), .q_rise(h_ri), .q_fall(h_fa), .conflict(h_cf)
`ifdef SR_CONFLICT_CNT_EN
    , .conflict_cnt(h_cnt)
`endif
  );

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(SR_MODE_RST_DOM),
                .RESET_VAL(4'b0000), .CNT_W(8)) u_rdom (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(d_q), .qbar(d_qb), .q_rise(d_ri), .q_fall(d_fa), .conflict(d_cf)
`ifdef SR_CONFLICT_CNT_EN
    , .conflict_cnt(d_cnt)
`endif
  );

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(SR_MODE_SET_DOM),
                .RESET_VAL(4'b0000), .CNT_W(8)) u_sdom (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(k_q), .qbar(k_qb), .q_rise(k_ri), .q_fall(k_fa), .conflict(k_cf)
`ifdef SR_CONFLICT_CNT_EN
    , .conflict_cnt(k_cnt)
`endif
  );

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(SR_MODE_TOGGLE),
                .RESET_VAL(4'b0000), .CNT_W(8)) u_tog (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(t_q), .qbar(t_qb), .q_rise(t_ri), .q_fall(t_fa), .conflict(t_cf)
`ifdef SR_CONFLICT_CNT_EN
    , .conflict_cnt(t_cnt)
`endif
  );

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(SR_MODE_HOLD),
                .RESET_VAL(4'b0101), .CNT_W(8)) u_rv (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(v_q), .qbar(v_qb), .q_rise(v_ri), .q_fall(v_fa), .conflict(v_cf)
`ifdef SR_CONFLICT_CNT_EN
    , .conflict_cnt(v_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; s = 4'h0; r = 4'h0;
    tick();
    chk("rst_q", 32'(h_q), 32'h0);
    chk("rst_qbar", 32'(h_qb), 32'hF);
    chk("rst_rise", 32'(h_ri), 32'h0);
    chk("rst_fall", 32'(h_fa), 32'h0);
    chk("rst_conf", 32'(h_cf), 32'h0);
    chk("rst_rv_q", 32'(v_q), 32'h5);
`ifdef SR_CONFLICT_CNT_EN
    chk("rst_cnt", 32'(h_cnt), 32'h0);
`endif
    reset = 1'b0;
    tick(); tick();
    chk("rel_rise", 32'(h_ri), 32'h0);
    chk("rel_rv_rise", 32'(v_ri), 32'h0);
    chk("rel_rv_fall", 32'(v_fa), 32'h0);

    // load 1010, then assert reset between edges
    en = 1'b1; s = 4'b1010; r = 4'h0;
    tick();
    chk("load_1010", 32'(h_q), 32'hA);
    en = 1'b0; s = 4'h0;
    #2 reset = 1'b1;
    #1;
    chk("async_q", 32'(h_q), 32'h0);
    chk("async_qbar", 32'(h_qb), 32'hF);
    chk("async_rv_q", 32'(v_q), 32'h5);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("rel2_rise", 32'(h_ri), 32'h0);
    chk("rel2_fall", 32'(h_fa), 32'h0);

    // set/reset, rise pulse a cycle later, one cycle wide
    en = 1'b1; s = 4'b0011; r = 4'b0100;
    tick();
    chk("sr_q", 32'(h_q), 32'h3);
    chk("sr_qbar", 32'(h_qb), 32'hC);
    chk("sr_rise_early", 32'(h_ri), 32'h0);
    s = 4'h0; r = 4'h0;
    tick();
    chk("rise_pulse", 32'(h_ri), 32'h3);
    tick();
    chk("rise_gone", 32'(h_ri), 32'h0);

    s = 4'hF;
    tick();
    chk("all_set", 32'(h_q), 32'hF);
    chk("all_set_tog", 32'(t_q), 32'hF);

    // s=r on bit 0 for three cycles
    s = 4'b0001; r = 4'b0001;
    tick();
    chk("hold_q", 32'(h_q), 32'hF);
    chk("rdom_q", 32'(d_q), 32'hE);
    chk("sdom_q", 32'(k_q), 32'hF);
    chk("tog_q_c1", 32'(t_q), 32'hE);
    chk("conf_hold", 32'(h_cf), 32'h1);
    chk("conf_rdom", 32'(d_cf), 32'h1);
    chk("conf_sdom", 32'(k_cf), 32'h1);
    chk("conf_tog", 32'(t_cf), 32'h1);
    tick();
    chk("tog_q_c2", 32'(t_q), 32'hF);
    chk("rdom_q_c2", 32'(d_q), 32'hE);
    tick();
    chk("tog_q_c3", 32'(t_q), 32'hE);
    s = 4'h0; r = 4'h0;
    tick();
    chk("conf_sticky", 32'(h_cf), 32'h1);
    chk("conf_sticky_s", 32'(k_cf), 32'h1);

    // en=0 ignores s and r
    en = 1'b0; s = 4'hF; r = 4'h0;
    tick();
    chk("en0_set", 32'(t_q), 32'hE);
    s = 4'h0; r = 4'hF;
    tick();
    chk("en0_rst", 32'(h_q), 32'hF);
    s = 4'hF; r = 4'hF;
    tick();
    chk("en0_conf", 32'(h_cf), 32'h1);

    // clr beats set and a same-cycle conflict
    en = 1'b1; clr = 1'b1; s = 4'hF; r = 4'b0001;
    tick();
    chk("clr_q", 32'(h_q), 32'h0);
    chk("clr_conf", 32'(h_cf), 32'h0);
    chk("clr_rv_q", 32'(v_q), 32'h5);
    chk("clr_rv_conf", 32'(v_cf), 32'h0);
`ifdef SR_CONFLICT_CNT_EN
    chk("clr_cnt0", 32'(h_cnt), 32'h0);
`endif
    clr = 1'b0; s = 4'h0; r = 4'h0;
    tick();
    chk("clr_fall", 32'(h_fa), 32'hF);
    chk("clr_rv_fall", 32'(v_fa), 32'hA);
    tick();
    chk("clr_fall_gone", 32'(v_fa), 32'h0);

`ifdef SR_CONFLICT_CNT_EN
    s = 4'b0011; r = 4'b0011;
    tick(); tick();
    chk("cnt_2", 32'(h_cnt), 32'h2);
    chk("cnt_2_w8", 32'(d_cnt), 32'h2);
    tick(); tick(); tick();
    chk("cnt_sat", 32'(h_cnt), 32'h3);
    chk("cnt_5_w8", 32'(d_cnt), 32'h5);
    en = 1'b0;
    tick();
    chk("cnt_en0", 32'(d_cnt), 32'h5);
    en = 1'b1; clr = 1'b1;
    tick();
    chk("cnt_clr", 32'(h_cnt), 32'h0);
    clr = 1'b0; s = 4'h0; r = 4'h0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sr_reg_bank.md
Name: sr_reg_bank

Overview:
- Parametrised, multi-channel successor to the single-bit SR flip-flop: WIDTH independent clocked SR bits sharing one clock, enable and synchronous clear.
- The S=R=1 case is resolved by a compile-time mode rather than left undefined.
- Adds sticky per-bit conflict flags and one-cycle rise/fall pulses per bit.
- Sits between control/status logic and consumers that need latched event bits with clean edges.

Parameters:
- WIDTH, 4, number of SR channels (1..32).
- CONFLICT_MODE, SR_MODE_HOLD, S=R=1 resolution: HOLD=0, SET_DOM=1, RST_DOM=2, TOGGLE=3.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by reset and by clr.
- CNT_W, 8, width of the optional conflict counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  update enable; en=0 holds q.
- clr  in  1  synchronous clear to RESET_VAL; overrides s/r and en.
- s  in  WIDTH  per-bit set.
- r  in  WIDTH  per-bit reset.
- q  out  WIDTH  registered state.
- qbar  out  WIDTH  always ~q, combinational from q.
- q_rise  out  WIDTH  one-cycle pulse in the cycle after q[i] goes 0->1.
- q_fall  out  WIDTH  one-cycle pulse in the cycle after q[i] goes 1->0.
- conflict  out  WIDTH  sticky flag: bit i set once s[i]&r[i]&en has been sampled.
- conflict_cnt  out  CNT_W  conflict-cycle counter; present only with SR_CONFLICT_CNT_EN.

Behaviour:
- Reset (async, immediate): q=RESET_VAL, qbar=~RESET_VAL, q_rise=0, q_fall=0, conflict=0, conflict_cnt=0. The internal q_prev register is also set to RESET_VAL, so no edge pulse is generated on release.
- Priority at each rising clk edge: reset > clr > en > hold.
- clr=1: q<=RESET_VAL and conflict<=0. Edge pulses still reflect the resulting change in q.
- en=1, per bit:
  - s=0,r=0: hold.
  - s=1,r=0: q=1.
  - s=0,r=1: q=0.
  - s=1,r=1: resolved by CONFLICT_MODE. HOLD keeps q. SET_DOM gives 1. RST_DOM gives 0. TOGGLE gives ~q.
- Latency: one clock from s/r to q. qbar has zero extra latency.
- Edge pulses are registered: q_rise = q & ~q_prev, computed one cycle after q changes. Each pulse is high for exactly one cycle, even when q toggles every cycle.
- conflict[i] sets on any sampled en&s[i]&r[i], in every mode including SET_DOM and RST_DOM. It clears only on reset or clr. When clr and a conflict occur in the same cycle, clr wins.
- Bits are fully independent; no cross-channel interaction.
- s/r are ignored while en=0 and are not latched for later.
- An illegal CONFLICT_MODE value (>3) is a compile-time error, enforced by an elaboration check.

Optional Feature:
- Macro SR_CONFLICT_CNT_EN.
- Defined: conflict_cnt increments by 1 in each enabled cycle where any bit has s&r. It counts cycles, not bits. It saturates at 2^CNT_W-1 and is cleared by reset or clr.
- Undefined: the conflict_cnt port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package sr_pkg holds:
  - sr_mode_t enum: SR_MODE_HOLD, SR_MODE_SET_DOM, SR_MODE_RST_DOM, SR_MODE_TOGGLE.
  - Function sr_next(q,s,r,mode) returning the next-state bit.
- One sub-module, sr_cell: a single-bit flop with en/clr, conflict flag and edge detect. It is instantiated WIDTH times by generate.
- The counter lives in the top level.

Test Plan:
- WIDTH=4, RESET_VAL=0:
  - Assert reset mid-cycle while q=4'b1010 -> q=0, qbar=4'hF immediately, before the next edge.
  - Release reset -> no q_rise/q_fall pulses.
- en=1, s=4'b0011, r=4'b0100 for one cycle -> next cycle q=4'b0011. The following cycle q_rise=4'b0011 for one cycle only.
- Set q=4'b1111, then s=r=4'b0001:
  - HOLD -> q=4'b1111.
  - RST_DOM -> q=4'b1110.
  - TOGGLE, held 3 cycles -> q[0] goes 0,1,0.
  - All modes -> conflict=4'b0001 and stays set.
- en=0 with s=4'hF -> q unchanged. clr=1 together with s=4'hF, en=1 -> q=RESET_VAL and conflict=0.
- SR_CONFLICT_CNT_EN, CNT_W=2:
  - Five conflict cycles with two bits conflicting each cycle -> conflict_cnt=3 (saturated).
  - clr -> conflict_cnt=0.
- RESET_VAL=4'b0101: reset -> q=4'b0101. clr after s=4'hF -> q=4'b0101, q_fall=4'b1010 on the next cycle.
